// File: rtl/axi_slave_mem_responder.sv
// AXI4 subordinate memory model: independent write (AW/W/B) and read (AR/R) FSMs
// over a DEPTH-word array, FIXED/INCR bursts only, one outstanding burst per direction.
module axi_slave_mem_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] sz,
                                                      input logic [1:0] bt);
    return (bt == 2'b01) ? a + (ADDR_WIDTH'(1) << sz) : a;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  wstate_e               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
  logic                  mem_we;

  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;

  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    bresp_d  = bresp_q;
    awready  = (wstate_q == W_IDLE);
    wready   = (wstate_q == W_DATA);
    bvalid   = (wstate_q == W_RESP);
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: if (awvalid) begin
        wid_d    = awid;
        waddr_d  = awaddr;
        wlen_d   = awlen;
        wsize_d  = awsize;
        wburst_d = awburst;
        wcnt_d   = '0;
        wstate_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        mem_we  = (wcnt_q <= wlen_q) && !wburst_q[1];
        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
        wcnt_d  = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        if (wlast) begin
          // counter still holds the index of this beat, so index==len means len+1 beats
          bresp_d  = (wburst_q[1] || (wcnt_q != wlen_q)) ? 2'b10 : 2'b00;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  assign bid   = wid_q;
  assign bresp = bresp_q;

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    arready  = (rstate_q == R_IDLE);
    rvalid   = (rstate_q == R_DATA);
    rlast    = rvalid && (rcnt_q == rlen_q);
    rresp    = (rvalid && rburst_q[1]) ? 2'b10 : 2'b00;
    // combinational read of the array gives pre-write data on a same-cycle collision
    rdata    = (rvalid && !rburst_q[1]) ? mem_q[raddr_q[LSB +: IW]] : '0;
    case (rstate_q)
      R_IDLE: if (arvalid) begin
        rid_d    = arid;
        raddr_d  = araddr;
        rlen_d   = arlen;
        rsize_d  = arsize;
        rburst_d = arburst;
        rcnt_d   = '0;
        rstate_d = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rlast) rstate_d = R_IDLE;
        else begin
          raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
          rcnt_d  = rcnt_q + 8'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign rid = rid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      bresp_q  <= '0;
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < SW; b++)
        if (wstrb[b]) mem_q[waddr_q[LSB +: IW]][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed plus randomized bench for axi_slave_mem_responder against a word-array model.
module tb_axi_slave_mem_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic [63:0] wdata = '0, rdata;

  int vectors = 0, miscompares = 0;
  logic [63:0] mdl [256];
  logic [63:0] wd [$];
  logic [7:0]  ws [$];

  axi_slave_mem_responder dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd8) % 32'd256);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt);
    return (bt == 2'b01) ? a + (32'd1 << sz) : a;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mdl[i] = '0;
  endtask

  task automatic fill(input int n, input bit rnd, input logic [63:0] base, input logic [7:0] strb);
    wd.delete(); ws.delete();
    for (int i = 0; i < n; i++) begin
      wd.push_back(rnd ? {$urandom, $urandom} : base * 64'(i + 1));
      ws.push_back(rnd ? 8'($urandom) : strb);
    end
  endtask

  task automatic aw_issue(input [3:0] id, input [31:0] addr, input [7:0] len, input [2:0] sz, input [1:0] bt);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = sz; awburst = bt; awvalid = 1;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_wait", 64'(t < 50), 1);
    @(negedge clk); awvalid = 0;
    chk("wready_after_aw", wready, 1);
    chk("awready_busy", awready, 0);
  endtask

  task automatic wr(input [3:0] id, input [31:0] addr, input [7:0] len, input [2:0] sz,
                    input [1:0] bt, input int nbeats, input int bhold);
    logic [31:0] a = addr;
    bit sup = (bt < 2);
    aw_issue(id, addr, len, sz, bt);
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      chk("wready_beat", wready, 1);
      if (sup && i <= int'(len))
        for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[widx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      a = step(a, sz, bt);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    chk("bvalid_after_wlast", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, (!sup || nbeats != int'(len) + 1) ? 2'b10 : 2'b00);
    for (int h = 0; h < bhold; h++) begin
      awvalid = 1;
      chk("bvalid_hold", bvalid, 1);
      chk("awready_hold", awready, 0);
      @(negedge clk);
    end
    awvalid = 0; bready = 1;
    @(negedge clk); bready = 0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  task automatic rd(input [3:0] id, input [31:0] addr, input [7:0] len, input [2:0] sz,
                    input [1:0] bt, input int mode);
    logic [31:0] a = addr;
    bit sup = (bt < 2);
    int t = 0, stalls;
    arid = id; araddr = addr; arlen = len; arsize = sz; arburst = bt; arvalid = 1;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_wait", 64'(t < 50), 1);
    @(negedge clk); arvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      stalls = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s <= stalls; s++) begin
        rready = (s == stalls);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, sup ? mdl[widx(a)] : 64'h0);
        chk("rresp", rresp, sup ? 2'b00 : 2'b10);
        chk("rlast", rlast, i == int'(len));
        chk("rid", rid, id);
        @(negedge clk);
      end
      a = step(a, sz, bt);
    end
    rready = 0;
    chk("rvalid_end", rvalid, 0);
    chk("arready_end", arready, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_bresp", bresp, 0); chk("rst_bid", bid, 0);
    chk("rst_rlast", rlast, 0); chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0); chk("rst_rdata", rdata, 0);
    rst = 0;
    @(negedge clk);
    chk_idle_outputs("post_rst");

    // INCR burst and read-back
    fill(5, 0, 64'h11, 8'hFF);
    wr(4'd3, 32'h40, 8'd4, 3'd3, 2'b01, 5, 0);
    rd(4'd3, 32'h40, 8'd4, 3'd3, 2'b01, 0);
    chk("mem8_model", mdl[8], 64'h11);
    chk("mem12_model", mdl[12], 64'h55);

    // partial strobe
    fill(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(4'd1, 32'h0, 8'd0, 3'd3, 2'b00, 1, 0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    wr(4'd1, 32'h0, 8'd0, 3'd3, 2'b00, 1, 0);
    rd(4'd1, 32'h0, 8'd0, 3'd3, 2'b01, 0);
    chk("strobe_model", mdl[0], 64'hFFFF_FFFF_0000_0000);

    // early wlast: 3 beats of a len=4 burst into a zero region
    fill(5, 0, 64'hA5A5, 8'hFF);
    wr(4'd5, 32'h200, 8'd4, 3'd3, 2'b01, 3, 0);
    rd(4'd5, 32'h200, 8'd4, 3'd3, 2'b01, 0);

    // WRAP read and write are rejected
    rd(4'd6, 32'h40, 8'd1, 3'd3, 2'b10, 0);
    fill(2, 1, 0, 0);
    wr(4'd7, 32'h40, 8'd1, 3'd3, 2'b10, 2, 0);
    rd(4'd7, 32'h40, 8'd1, 3'd3, 2'b01, 0);

    // B backpressure and R toggling
    fill(8, 1, 0, 0);
    wr(4'd9, 32'h300, 8'd7, 3'd3, 2'b01, 8, 5);
    rd(4'd9, 32'h300, 8'd7, 3'd3, 2'b01, 1);

    // aliasing and address wrap
    fill(1, 0, 64'hCAFE_F00D, 8'hFF);
    wr(4'd2, 32'h800, 8'd0, 3'd3, 2'b01, 1, 0);
    rd(4'd2, 32'h0, 8'd0, 3'd3, 2'b01, 0);
    chk("alias_model", mdl[0], 64'hCAFE_F00D);
    fill(2, 0, 64'h1234_5678, 8'hFF);
    wr(4'd4, 32'h7F8, 8'd1, 3'd3, 2'b01, 2, 0);
    rd(4'd4, 32'hFF8, 8'd0, 3'd3, 2'b01, 0);
    rd(4'd4, 32'h0, 8'd0, 3'd3, 2'b01, 0);
    chk("wrap_model0", mdl[0], 64'h2468_ACF0);

    // randomized bursts
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a = $urandom;
      logic [7:0]  l = 8'($urandom_range(0, 7));
      logic [2:0]  s = 3'($urandom_range(0, 3));
      logic [1:0]  b = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      int nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : int'(l) + 1;
      fill(nb, 1, 0, 0);
      wr(4'($urandom), a, l, s, b, nb, int'($urandom_range(0, 2)));
      rd(4'($urandom), a, l, s, b, 2);
      rd(4'($urandom), $urandom, 8'($urandom_range(0, 3)), 3'd3, 2'b01, 2);
    end

    // reset during beat 2 of a write
    fill(5, 1, 0, 0);
    aw_issue(4'd8, 32'h100, 8'd4, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = 8'hFF; wlast = 0;
      @(negedge clk);
    end
    wdata = wd[2];
    rst = 1; #1;
    chk_idle_outputs("rst_wr");
    clear_model();
    wvalid = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk_idle_outputs("rst_wr_rel");

    // reset in the middle of a read
    fill(4, 1, 0, 0);
    wr(4'd1, 32'h20, 8'd3, 3'd3, 2'b01, 4, 0);
    arid = 4'd2; araddr = 32'h20; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1;
    @(negedge clk); arvalid = 0; rready = 1;
    @(negedge clk);
    chk("rd_midburst_rvalid", rvalid, 1);
    rst = 1; #1;
    chk_idle_outputs("rst_rd");
    chk("rst_rd_rdata", rdata, 0);
    clear_model();
    rready = 0;
    @(negedge clk); rst = 0;
    @(negedge clk);
    rd(4'd0, 32'h20, 8'd3, 3'd3, 2'b01, 0);
    rd(4'd0, 32'h100, 8'd4, 3'd3, 2'b01, 0);
    rd(4'd0, 32'h0, 8'd0, 3'd3, 2'b01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
